eeprom_burst_test: RTL and testbench



---
 rtl/eeprom_burst_test.sv | 227 ++++++++++++++++++++++
 tb/tb_eeprom_burst_test.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_burst_test.sv
// rtl/eeprom_burst_test.sv - EEPROM page-burst write/read-back test sequencer driving iic_master
// Optional: define EEPROM_ERR_INJECT_EN to add err_inject, which flips bit 0 of write byte 0.
module eeprom_burst_test #(
    parameter int CLK_FRE     = 50,
    parameter int TEST_FRE    = 2,
    parameter int TICK_CYCLES = CLK_FRE * 1000000 / TEST_FRE,
    parameter int TWR_CYCLES  = CLK_FRE * 5000,
    parameter int REG_ADDR_EX = 1,
    parameter int BURST_LEN   = 8,
    parameter int PAGE_SIZE   = 32,
    parameter int ADDR_LIMIT  = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef EEPROM_ERR_INJECT_EN
    input  logic                       err_inject,
`endif
    output logic                       iic_start,
    input  logic                       iic_busy,
    output logic                       reg_rw,
    output logic [8+REG_ADDR_EX*8-1:0] reg_addr,
    output logic [7:0]                 send_data,
    input  logic [7:0]                 recv_data,
    input  logic                       brust_ready,
    output logic                       brust_vaild,
    output logic                       data_beat,
    output logic [15:0]                pass_cnt,
    output logic [15:0]                err_cnt,
    output logic                       round_err
);

    localparam int AW  = 8 + REG_ADDR_EX * 8;
    localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int WW  = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
    localparam int IW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int MW  = $clog2(BURST_LEN + 1);
    localparam int BW  = $clog2(ADDR_LIMIT + BURST_LEN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);
    localparam logic          MULTI    = (BURST_LEN > 1);

    if (BURST_LEN < 1 || PAGE_SIZE % BURST_LEN != 0) begin : g_cfg_err
        $error("BURST_LEN must divide PAGE_SIZE");
    end

    typedef enum logic [2:0] {
        IDLE, WR_START, WR_BURST, WR_WAIT, RD_START, RD_BURST, CHECK, NEXT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [WW-1:0]   twr_cnt_q, twr_cnt_d;
    logic [BW-1:0]   base_q, base_d;
    logic [7:0]      seed_q, seed_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [MW-1:0]   mis_q, mis_d;
    logic            last_q, last_d;
    logic            busy_prev_q, busy_seen_q, busy_seen_d;
    logic            iic_start_q, iic_start_d;
    logic            reg_rw_q, reg_rw_d;
    logic [AW-1:0]   reg_addr_q, reg_addr_d;
    logic [7:0]      send_data_q, send_data_d;
    logic            brust_vaild_q, brust_vaild_d;
    logic            data_beat_q, data_beat_d;
    logic [15:0]     pass_cnt_q, pass_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            round_err_q, round_err_d;

    logic            tick;
    logic            busy_fall;
    logic            advance;
    logic [7:0]      inj_mask;
    logic [16:0]     err_sum;
    logic [BW-1:0]   base_sum;

`ifdef EEPROM_ERR_INJECT_EN
    assign inj_mask = {7'b0, err_inject};
`else
    assign inj_mask = 8'h00;
`endif

    assign tick      = (tick_cnt_q == TW'(TICK_CYCLES - 1));
    // A stale low busy right after start must not end the burst early.
    assign busy_fall = busy_seen_q && busy_prev_q && !iic_busy;
    assign advance   = brust_ready && !last_q;
    assign err_sum   = {1'b0, err_cnt_q} + 17'(mis_q);
    assign base_sum  = base_q + BW'(BURST_LEN);

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + TW'(1);
        twr_cnt_d     = twr_cnt_q;
        base_d        = base_q;
        seed_d        = seed_q;
        idx_d         = idx_q;
        mis_d         = mis_q;
        last_d        = last_q;
        busy_seen_d   = busy_seen_q;
        iic_start_d   = 1'b0;
        reg_rw_d      = reg_rw_q;
        reg_addr_d    = reg_addr_q;
        send_data_d   = send_data_q;
        brust_vaild_d = brust_vaild_q;
        data_beat_d   = data_beat_q;
        pass_cnt_d    = pass_cnt_q;
        err_cnt_d     = err_cnt_q;
        round_err_d   = round_err_q;

        case (state_q)
            IDLE: begin
                if (tick && !iic_busy) state_d = WR_START;
            end
            WR_START, RD_START: begin
                reg_rw_d      = (state_q == RD_START);
                reg_addr_d    = AW'(base_q);
                idx_d         = '0;
                mis_d         = '0;
                last_d        = 1'b0;
                busy_seen_d   = 1'b0;
                brust_vaild_d = MULTI;
                iic_start_d   = 1'b1;
                if (state_q == WR_START) begin
                    send_data_d = seed_q ^ inj_mask;
                    state_d     = WR_BURST;
                end else begin
                    state_d     = RD_BURST;
                end
            end
            WR_BURST, RD_BURST: begin
                busy_seen_d = busy_seen_q | iic_busy;
                if (advance) begin
                    if (state_q == RD_BURST && recv_data != seed_q + 8'(idx_q)) begin
                        mis_d = mis_q + MW'(1);
                    end
                    // The last byte's pulse only latches completion; later pulses are ignored.
                    if (idx_q == LAST_IDX) begin
                        last_d = 1'b1;
                    end else begin
                        idx_d         = idx_q + IW'(1);
                        brust_vaild_d = (int'(idx_q) + 2 < BURST_LEN);
                        if (state_q == WR_BURST) send_data_d = seed_q + 8'(idx_q) + 8'd1;
                    end
                end
                if (busy_fall) begin
                    twr_cnt_d = '0;
                    state_d   = (state_q == WR_BURST) ? WR_WAIT : CHECK;
                end
            end
            WR_WAIT: begin
                if (twr_cnt_q == WW'(TWR_CYCLES - 1)) begin
                    state_d = RD_START;
                end else begin
                    twr_cnt_d = twr_cnt_q + WW'(1);
                end
            end
            CHECK: begin
                err_cnt_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
                round_err_d = (mis_q != '0);
                if (mis_q == '0) begin
                    data_beat_d = ~data_beat_q;
                    if (pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
                end
                state_d = NEXT;
            end
            NEXT: begin
                seed_d  = seed_q + 8'd1;
                base_d  = (base_sum >= BW'(ADDR_LIMIT)) ? '0 : base_sum;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            twr_cnt_q     <= '0;
            base_q        <= '0;
            seed_q        <= '0;
            idx_q         <= '0;
            mis_q         <= '0;
            last_q        <= 1'b0;
            busy_prev_q   <= 1'b0;
            busy_seen_q   <= 1'b0;
            iic_start_q   <= 1'b0;
            reg_rw_q      <= 1'b0;
            reg_addr_q    <= '0;
            send_data_q   <= '0;
            brust_vaild_q <= 1'b0;
            data_beat_q   <= 1'b0;
            pass_cnt_q    <= '0;
            err_cnt_q     <= '0;
            round_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            twr_cnt_q     <= twr_cnt_d;
            base_q        <= base_d;
            seed_q        <= seed_d;
            idx_q         <= idx_d;
            mis_q         <= mis_d;
            last_q        <= last_d;
            busy_prev_q   <= iic_busy;
            busy_seen_q   <= busy_seen_d;
            iic_start_q   <= iic_start_d;
            reg_rw_q      <= reg_rw_d;
            reg_addr_q    <= reg_addr_d;
            send_data_q   <= send_data_d;
            brust_vaild_q <= brust_vaild_d;
            data_beat_q   <= data_beat_d;
            pass_cnt_q    <= pass_cnt_d;
            err_cnt_q     <= err_cnt_d;
            round_err_q   <= round_err_d;
        end
    end

    assign iic_start   = iic_start_q;
    assign reg_rw      = reg_rw_q;
    assign reg_addr    = reg_addr_q;
    assign send_data   = send_data_q;
    assign brust_vaild = brust_vaild_q;
    assign data_beat   = data_beat_q;
    assign pass_cnt    = pass_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign round_err   = round_err_q;

endmodule

// File: tb/tb_eeprom_burst_test.sv
// tb/tb_eeprom_burst_test.sv - self-checking bench for eeprom_burst_test with an echoing iic_master model
`timescale 1ns/1ps
module tb_eeprom_burst_test;

    localparam int TICK = 400;
    localparam int TWR  = 100;
    localparam int BL   = 4;
    localparam int ALIM = 8;
`ifdef EEPROM_ERR_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        iic_start;
    logic        iic_busy;
    logic        reg_rw;
    logic [15:0] reg_addr;
    logic [7:0]  send_data;
    logic [7:0]  recv_data;
    logic        brust_ready;
    logic        brust_vaild;
    logic        data_beat;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic        round_err;
    logic        err_inject;

    logic        m_busy;
    logic        force_busy;
    bit          inj_knob;
    bit          extra_pulse;
    int          bad_byte;

    assign iic_busy   = m_busy | force_busy;
    assign err_inject = inj_knob;

    eeprom_burst_test #(
        .CLK_FRE(50), .TEST_FRE(2), .TICK_CYCLES(TICK), .TWR_CYCLES(TWR),
        .REG_ADDR_EX(1), .BURST_LEN(BL), .PAGE_SIZE(32), .ADDR_LIMIT(ALIM)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef EEPROM_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .iic_start(iic_start),
        .iic_busy(iic_busy),
        .reg_rw(reg_rw),
        .reg_addr(reg_addr),
        .send_data(send_data),
        .recv_data(recv_data),
        .brust_ready(brust_ready),
        .brust_vaild(brust_vaild),
        .data_beat(data_beat),
        .pass_cnt(pass_cnt),
        .err_cnt(err_cnt),
        .round_err(round_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // iic_master stand-in: a 16-byte EEPROM that echoes writes and can corrupt one read byte.
    logic [7:0]  mem [16];
    logic [7:0]  wr_cap [4];
    logic [15:0] wr_addr_cap, rd_addr_cap, t_addr, ma;
    logic [7:0]  wb, sd_after_extra;
    logic        t_rw;
    bit          more, in_write;
    int          mk;
    int          rd_done_cnt;

    initial begin
        m_busy = 1'b0; brust_ready = 1'b0; recv_data = 8'h00;
        rd_done_cnt = 0; in_write = 1'b0; sd_after_extra = 8'h00;
        wr_addr_cap = 16'hFFFF; rd_addr_cap = 16'hFFFF;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) wr_cap[i] = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (iic_start === 1'b1) begin
                t_rw = reg_rw; t_addr = reg_addr; mk = 0; more = 1'b1; m_busy = 1'b1;
                if (t_rw) rd_addr_cap = t_addr;
                else begin wr_addr_cap = t_addr; in_write = 1'b1; end
                wb = send_data;
                while (more) begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                    ma = t_addr + 16'(mk);
                    if (t_rw) recv_data = (mk == bad_byte) ? 8'hFF : mem[ma[3:0]];
                    else begin
                        mem[ma[3:0]] = wb;
                        if (mk < 4) wr_cap[2'(mk)] = wb;
                    end
                    more = brust_vaild;
                    brust_ready = 1'b1;
                    @(posedge clk); #1;
                    brust_ready = 1'b0;
                    mk++;
                    wb = send_data;
                    if (mk >= 16) more = 1'b0;
                end
                if (extra_pulse) begin
                    @(posedge clk); #1; brust_ready = 1'b1;
                    @(posedge clk); #1; brust_ready = 1'b0;
                    if (!t_rw) sd_after_extra = send_data;
                end
                repeat (2) @(posedge clk);
                #1;
                m_busy = 1'b0; in_write = 1'b0;
                if (t_rw) rd_done_cnt++;
            end
        end
    end

    // Reference: one round writes seed+k at base+k, reads back, counts bytes differing from seed+k.
    int md_seed, md_base, md_pass, md_err;
    bit md_beat, md_rerr;

    task automatic model_reset();
        md_seed = 0; md_base = 0; md_pass = 0; md_err = 0; md_beat = 0; md_rerr = 0;
    endtask

    task automatic model_round(input int bad, input bit inj,
                               output logic [15:0] e_addr, output logic [31:0] e_bytes);
        int   mism;
        logic [7:0] w, r, pat;
        e_addr = 16'(md_base); e_bytes = '0; mism = 0;
        for (int k = 0; k < BL; k++) begin
            pat = 8'((md_seed + k) % 256);
            w   = (k == 0 && inj) ? (pat ^ 8'h01) : pat;
            e_bytes = {e_bytes[23:0], w};
            r   = (k == bad) ? 8'hFF : w;
            if (r != pat) mism++;
        end
        md_err  = (md_err + mism > 65535) ? 65535 : md_err + mism;
        md_rerr = (mism != 0);
        if (mism == 0) begin
            md_pass = (md_pass == 65535) ? 65535 : md_pass + 1;
            md_beat = ~md_beat;
        end
        md_seed = (md_seed + 1) % 256;
        md_base = (md_base + BL) % ALIM;
    endtask

    typedef struct {
        int          bad;
        logic [15:0] addr;
        logic [31:0] bytes;
        logic [15:0] pass;
        logic [15:0] err;
        bit          beat;
        bit          rerr;
    } vec_t;
    vec_t vecs [4];

    task automatic do_round(input string tag, input int bad, input bit extra, input bit inj,
                            input bit use_tab, input vec_t v);
        logic [15:0] e_addr;
        logic [31:0] e_bytes;
        int          start, cyc;
        bad_byte = bad; extra_pulse = extra; inj_knob = inj;
        start = rd_done_cnt; cyc = 0;
        while (rd_done_cnt == start && cyc < 3000) begin
            @(negedge clk); cyc++;
        end
        check({tag, "_done"}, 32'(rd_done_cnt != start), 32'd1);
        repeat (5) @(negedge clk);
        model_round(bad, inj && INJ_ON, e_addr, e_bytes);
        if (use_tab) begin
            check({tag, "_wr_addr"}, 32'(wr_addr_cap), 32'(v.addr));
            check({tag, "_rd_addr"}, 32'(rd_addr_cap), 32'(v.addr));
            check({tag, "_wr_bytes"}, {wr_cap[0], wr_cap[1], wr_cap[2], wr_cap[3]}, v.bytes);
            check({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(v.pass));
            check({tag, "_err_cnt"}, 32'(err_cnt), 32'(v.err));
            check({tag, "_data_beat"}, 32'(data_beat), 32'(v.beat));
            check({tag, "_round_err"}, 32'(round_err), 32'(v.rerr));
        end else begin
            check({tag, "_wr_addr"}, 32'(wr_addr_cap), 32'(e_addr));
            check({tag, "_rd_addr"}, 32'(rd_addr_cap), 32'(e_addr));
            check({tag, "_wr_bytes"}, {wr_cap[0], wr_cap[1], wr_cap[2], wr_cap[3]}, e_bytes);
            check({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(md_pass));
            check({tag, "_err_cnt"}, 32'(err_cnt), 32'(md_err));
            check({tag, "_data_beat"}, 32'(data_beat), 32'(md_beat));
            check({tag, "_round_err"}, 32'(round_err), 32'(md_rerr));
        end
        if (extra) check({tag, "_extra_ready_send_data"}, 32'(sd_after_extra), 32'(e_bytes[7:0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iic_start"}, 32'(iic_start), 32'd0);
        check({tag, "_reg_rw"}, 32'(reg_rw), 32'd0);
        check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        check({tag, "_send_data"}, 32'(send_data), 32'd0);
        check({tag, "_brust_vaild"}, 32'(brust_vaild), 32'd0);
        check({tag, "_data_beat"}, 32'(data_beat), 32'd0);
        check({tag, "_pass_cnt"}, 32'(pass_cnt), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_round_err"}, 32'(round_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, starts, bad;
        vec_t nv;
        vecs[0] = '{bad: -1, addr: 16'h0000, bytes: 32'h00010203, pass: 16'd1, err: 16'd0, beat: 1'b1, rerr: 1'b0};
        vecs[1] = '{bad: -1, addr: 16'h0004, bytes: 32'h01020304, pass: 16'd2, err: 16'd0, beat: 1'b0, rerr: 1'b0};
        vecs[2] = '{bad:  2, addr: 16'h0000, bytes: 32'h02030405, pass: 16'd2, err: 16'd1, beat: 1'b0, rerr: 1'b1};
        vecs[3] = '{bad: -1, addr: 16'h0004, bytes: 32'h03040506, pass: 16'd3, err: 16'd1, beat: 1'b1, rerr: 1'b0};
        nv = vecs[0];

        rst = 1'b1; force_busy = 1'b0; inj_knob = 1'b0; extra_pulse = 1'b0; bad_byte = -1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 4; i++) begin
            do_round($sformatf("tab%0d", i), vecs[i].bad, 1'b0, 1'b0, 1'b1, vecs[i]);
        end

        for (int i = 0; i < 6; i++) begin
            bad = int'($urandom_range(0, 5));
            if (bad > 3) bad = -1;
            do_round($sformatf("rnd%0d", i), bad, 1'($urandom_range(0, 1)), 1'b0, 1'b0, nv);
        end

        // Reset in the middle of a write burst while the abandoned master stays busy.
        cyc = 0;
        while (!in_write && cyc < 3000) begin
            @(negedge clk); cyc++;
        end
        check("rst_write_seen", 32'(in_write), 32'd1);
        repeat (2) @(negedge clk);
        force_busy = 1'b1; extra_pulse = 1'b0; bad_byte = -1; inj_knob = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        starts = 0;
        for (int c = 1; c <= TICK + 50; c++) begin
            @(negedge clk);
            if (iic_start) starts++;
        end
        check("no_start_while_busy", 32'(starts), 32'd0);
        force_busy = 1'b0;
        cyc = TICK + 50;
        while (!iic_start && cyc < 3 * TICK) begin
            @(negedge clk); cyc++;
        end
        check("restart_cycle", 32'(cyc), 32'(2 * TICK + 1));
        do_round("post_rst_a", -1, 1'b0, 1'b1, 1'b0, nv);
        do_round("post_rst_b", -1, 1'b0, 1'b0, 1'b0, nv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
